multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle successor to the single-cycle general controller. It is an FSM that sequences each MIPS-subset instruction through IF/ID/EX/MEM/WB. It emits the same datapath control set per state, plus PC/IR write enables, and performs a ready/valid-style wait on a shared instruction/data memory. It adds a memory timeout watchdog and a retired-instruction counter.

Parameters:
ALUOP_W, 4, width of ALUOp output
CNT_W, 32, width of instret counter
MEM_TIMEOUT, 15, max cycles waiting on mem_ready before bus error; 0 = wait forever
TIMER_W, 4, width of timeout counter; must satisfy 2^TIMER_W > MEM_TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
instruction  in  32  current IR contents (valid from ID onward)
zero  in  1  ALU zero flag, sampled in EX
mem_ready  in  1  memory completes the current access this cycle
PCWr  out  1  PC load enable
PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target, 3=trap vector
IRWr  out  1  IR load enable
MemRd  out  1  memory read request (fetch or load)
MemWr  out  1  memory write request
RegWr, ALUSrc, RegDst, MemToReg, ExtOp, Link, RType  out  1 each  datapath controls, same meaning as the single-cycle controller
ALUOp  out  ALUOP_W  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=LUI 15=decode funct
state  out  3  0=IF 1=ID 2=EX 3=MEM 4=WB 5=TRAP
bus_err  out  1  one-cycle pulse on memory timeout
trap  out  1  one-cycle pulse in TRAP (always 0 without the macro)
instret  out  CNT_W  retired-instruction count

Behaviour:
- Registers: state, timeout counter, instret. All controls are combinational from state and instruction. Outputs not asserted in the current state are 0.
- Reset (rst=1 at a clk edge): state=IF, timer=0, instret=0. Reset mid-access aborts the access and issues no write.
- Decode:
  - opcode 0 with funct!=0 → R (RType=1, RegDst=1, ALUOp=15).
  - 0x00000000 is NOP.
  - lw 100011; sw 101011; beq 000100; bne 000101; addi 001000 (ExtOp=1); ori 001101 (ExtOp=0, ALUOp=OR); lui 001111 (ALUOp=LUI); j 000010; jal 000011.
  - Any other opcode is illegal.
- IF: MemRd=1. While mem_ready=0, stay and increment the timer. On mem_ready=1: IRWr=1, PCWr=1, PCSrc=0, → ID, timer=0.
- ID:
  - j: PCWr=1, PCSrc=2, → IF, retire.
  - jal: PCWr=1, PCSrc=2, → WB.
  - NOP or illegal (macro off): → IF, retire.
  - All other instructions: → EX.
- EX:
  - ALUSrc=1 for I-type/lw/sw. beq/bne use ALUOp=SUB.
  - beq/bne: PCWr = zero for beq, ~zero for bne; PCSrc=1; → IF, retire.
  - lw/sw: → MEM.
  - Otherwise: → WB.
- MEM: lw asserts MemRd; sw asserts MemWr. Hold until mem_ready. On mem_ready: lw → WB; sw → IF, retire. Timer=0.
- WB: RegWr=1 for exactly one cycle, → IF, retire.
  - lw: MemToReg=1.
  - jal: Link=1 (writes $31 with PC+4).
- Retire: instret += 1 on the transition to IF. Wraps modulo 2^CNT_W.
- Timeout: if MEM_TIMEOUT>0 and the timer reaches MEM_TIMEOUT while waiting in IF/MEM:
  - Pulse bus_err, drop requests, → IF, timer=0, no retire, no PC/IR/reg write.
  - If mem_ready=1 arrives in the same cycle as the limit, mem_ready wins and no bus_err is raised.
- Illegal state encodings (6,7) → IF next cycle.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an illegal opcode in ID goes to TRAP.
  - TRAP lasts one cycle: trap=1, PCWr=1, PCSrc=3, → IF.
  - No retire.
- Undefined: illegal opcodes behave as NOP. The TRAP state is unreachable, and trap is tied to 0.

Test Plan:
- Reset, then fetch add $3,$1,$2 (0x00221820) with mem_ready=1 every cycle → states IF,ID,EX,WB,IF; RegWr=1 only in WB; RType=1; ALUOp=15; instret=1.
- lw 0x8C220004 with mem_ready low 3 cycles in MEM → MemRd held 4 cycles; WB has MemToReg=1 and RegWr=1; 5+3 cycles total.
- beq with zero=1, then bne with zero=1 → first gives PCWr=1/PCSrc=1 in EX; second gives PCWr=0; both retire in 3 cycles.
- jal 0x0C000010 → ID: PCWr=1, PCSrc=2; WB: Link=1, RegWr=1. j gives no WB.
- MEM_TIMEOUT=15 with mem_ready stuck 0 in IF → bus_err pulses at cycle 15, instret unchanged, IF re-entered. A second run with mem_ready=1 on the limit cycle gives no bus_err.
- Opcode 0x3F: macro on → TRAP one cycle, trap=1, PCSrc=3. Macro off → ID→IF, instret+1.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with memory watchdog and instret.
// Optional ILLEGAL_TRAP_EN: illegal opcodes take a one-cycle TRAP to the trap vector instead of retiring as NOP.
module multi_cycle_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMER_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWr,
    output logic [1:0]         PCSrc,
    output logic               IRWr,
    output logic               MemRd,
    output logic               MemWr,
    output logic               RegWr,
    output logic               ALUSrc,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               ExtOp,
    output logic               Link,
    output logic               RType,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               bus_err,
    output logic               trap,
    output logic [CNT_W-1:0]   instret
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    // The timer holds the number of wait cycles already spent, so the limit cycle is the one where it reads MEM_TIMEOUT-1.
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    state_t             r_state, w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_instret;
    logic [5:0]         w_op;
    logic               w_r, w_nop, w_lw, w_sw, w_beq, w_bne, w_addi, w_ori, w_lui, w_j, w_jal, w_ill, w_br;
    logic               w_if, w_id, w_ex, w_mem, w_wb, w_trp, w_wait, w_tmo, w_retire;
    logic [ALUOP_W-1:0] w_aluop;
    assign w_op   = instruction[31:26];
    assign w_nop  = instruction == 32'd0;
    assign w_r    = w_op == 6'h00 && instruction[5:0] != 6'd0;
    assign w_lw   = w_op == 6'h23;
    assign w_sw   = w_op == 6'h2B;
    assign w_beq  = w_op == 6'h04;
    assign w_bne  = w_op == 6'h05;
    assign w_addi = w_op == 6'h08;
    assign w_ori  = w_op == 6'h0D;
    assign w_lui  = w_op == 6'h0F;
    assign w_j    = w_op == 6'h02;
    assign w_jal  = w_op == 6'h03;
    assign w_br   = w_beq | w_bne;
    assign w_ill  = !(w_r | w_nop | w_lw | w_sw | w_br | w_addi | w_ori | w_lui | w_j | w_jal);
    assign w_if   = r_state == S_IF;
    assign w_id   = r_state == S_ID;
    assign w_ex   = r_state == S_EX;
    assign w_mem  = r_state == S_MEM;
    assign w_wb   = r_state == S_WB;
    assign w_trp  = TRAP_EN && r_state == S_TRAP;
    assign w_wait = w_if | w_mem;
    // A ready arriving on the limit cycle completes the access, so the watchdog only fires without it.
    assign w_tmo  = (MEM_TIMEOUT > 0) && w_wait && !mem_ready && r_timer == LIMIT;
    assign w_aluop = w_r ? ALUOP_W'(15) : w_br ? ALUOP_W'(1) : w_ori ? ALUOP_W'(3) : w_lui ? ALUOP_W'(5) : ALUOP_W'(0);
    always_comb begin
        w_next   = S_IF;
        w_retire = 1'b0;
        case (r_state)
            S_IF: w_next = mem_ready ? S_ID : S_IF;
            S_ID: begin
                w_next   = w_jal ? S_WB : (w_j | w_nop) ? S_IF : w_ill ? (TRAP_EN ? S_TRAP : S_IF) : S_EX;
                w_retire = w_j | w_nop | (w_ill & !TRAP_EN);
            end
            S_EX: begin
                w_next   = w_br ? S_IF : (w_lw | w_sw) ? S_MEM : S_WB;
                w_retire = w_br;
            end
            S_MEM: begin
                w_next   = mem_ready ? (w_lw ? S_WB : S_IF) : (w_tmo ? S_IF : S_MEM);
                w_retire = mem_ready & !w_lw;
            end
            S_WB: begin
                w_next   = S_IF;
                w_retire = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end
    always_comb begin
        PCWr     = (w_if & mem_ready) | (w_id & (w_j | w_jal)) | (w_ex & ((w_beq & zero) | (w_bne & ~zero))) | w_trp;
        PCSrc    = w_trp ? 2'd3 : (w_id & (w_j | w_jal)) ? 2'd2 : (w_ex & w_br) ? 2'd1 : 2'd0;
        IRWr     = w_if & mem_ready;
        MemRd    = !w_tmo & (w_if | (w_mem & w_lw));
        MemWr    = !w_tmo & w_mem & w_sw;
        RegWr    = w_wb;
        ALUSrc   = w_ex & (w_addi | w_ori | w_lui | w_lw | w_sw);
        ExtOp    = w_ex & (w_addi | w_lw | w_sw | w_br);
        RType    = w_ex & w_r;
        ALUOp    = w_ex ? w_aluop : '0;
        RegDst   = w_wb & w_r;
        MemToReg = w_wb & w_lw;
        Link     = w_wb & w_jal;
        trap     = w_trp;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IF;
            r_timer   <= '0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_timer   <= (w_wait && !mem_ready && !w_tmo) ? r_timer + 1'b1 : '0;
            r_instret <= r_instret + CNT_W'(w_retire);
        end
    end
    assign state   = r_state;
    assign bus_err = w_tmo;
    assign instret = r_instret;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed and randomized instruction streams checked against a per-class phase model.
module tb_multi_cycle_ctrl;
    localparam int CW  = 4;
    localparam int TMO = 15;
    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [31:0] instruction;
    logic PCWr, IRWr, MemRd, MemWr, RegWr, ALUSrc, RegDst, MemToReg, ExtOp, Link, RType, bus_err, trap;
    logic [1:0] PCSrc;
    logic [3:0] ALUOp;
    logic [2:0] state;
    logic [CW-1:0] instret;
    logic [14:0] w_ctl;
    logic [CW-1:0] exp_ir;
    int total = 0;
    int bad = 0;
    typedef enum {C_R, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_ORI, C_LUI, C_J, C_JAL, C_NOP, C_ILL} cls_t;
    always #5 clk = ~clk;
    multi_cycle_ctrl #(.ALUOP_W(4), .CNT_W(CW), .MEM_TIMEOUT(TMO), .TIMER_W(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .MemToReg(MemToReg), .ExtOp(ExtOp), .Link(Link),
        .RType(RType), .ALUOp(ALUOp), .state(state), .bus_err(bus_err), .trap(trap), .instret(instret)
    );
    assign w_ctl = {PCWr, PCSrc, IRWr, MemRd, MemWr, RegWr, ALUSrc, RegDst, MemToReg, ExtOp, Link, RType, bus_err, trap};
    // dp = {ALUSrc, RegDst, MemToReg, ExtOp, Link, RType}
    function automatic logic [14:0] v(input logic pw, input logic [1:0] ps, input logic irw, input logic rd,
                                      input logic wr, input logic rw, input logic [5:0] dp, input logic be, input logic tr);
        return {pw, ps, irw, rd, wr, rw, dp, be, tr};
    endfunction
    function automatic cls_t cls_of(input logic [31:0] i);
        case (i[31:26])
            6'h00:   return (i == 32'd0) ? C_NOP : (i[5:0] != 6'd0) ? C_R : C_ILL;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h05:   return C_BNE;
            6'h08:   return C_ADDI;
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction
    task automatic chk(input string tag, input logic [2:0] est, input logic [14:0] ectl, input logic [3:0] eop);
        @(negedge clk);
        total++;
        assert (state === est) else begin bad++; $error("FAIL %s state got=%0d exp=%0d", tag, state, est); end
        total++;
        assert (w_ctl === ectl) else begin bad++; $error("FAIL %s ctl got=%b exp=%b", tag, w_ctl, ectl); end
        total++;
        assert (ALUOp === eop) else begin bad++; $error("FAIL %s ALUOp got=%0d exp=%0d", tag, ALUOp, eop); end
        @(posedge clk);
        #1;
    endtask
    task automatic chk_ir(input string tag);
        total++;
        assert (instret === exp_ir) else begin bad++; $error("FAIL %s instret got=%0d exp=%0d", tag, instret, exp_ir); end
        total++;
        assert (state === 3'd0) else begin bad++; $error("FAIL %s back_to_if got=%0d exp=0", tag, state); end
    endtask
    // One instruction: IF waits if_lat cycles, MEM waits mem_lat cycles; a wait reaching TMO cycles is a bus error.
    task automatic run(input logic [31:0] ins, input logic z, input int if_lat, input int mem_lat);
        cls_t c;
        logic br, lw, sw, pw;
        logic [3:0] op;
        c = cls_of(ins);
        instruction = ins;
        zero = z;
        for (int k = 0; k < if_lat; k++) begin
            mem_ready = 1'b0;
            if (k == TMO - 1) begin
                chk("if_tmo", 3'd0, v(0, 0, 0, 0, 0, 0, 6'd0, 1, 0), 4'd0);
                chk_ir("if_tmo_ir");
                return;
            end
            chk("if_wait", 3'd0, v(0, 0, 0, 1, 0, 0, 6'd0, 0, 0), 4'd0);
        end
        mem_ready = 1'b1;
        chk("if_done", 3'd0, v(1, 0, 1, 1, 0, 0, 6'd0, 0, 0), 4'd0);
        mem_ready = 1'($urandom);
        if (c == C_J || c == C_JAL) chk("id_jump", 3'd1, v(1, 2, 0, 0, 0, 0, 6'd0, 0, 0), 4'd0);
        else chk("id", 3'd1, v(0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 4'd0);
`ifdef ILLEGAL_TRAP_EN
        if (c == C_ILL) begin
            chk("trap", 3'd5, v(1, 3, 0, 0, 0, 0, 6'd0, 0, 1), 4'd0);
            chk_ir("trap_ir");
            return;
        end
`endif
        if (c == C_J || c == C_NOP || c == C_ILL) begin
            exp_ir++;
            chk_ir("id_ir");
            return;
        end
        lw = c == C_LW;
        sw = c == C_SW;
        if (c != C_JAL) begin
            br = c == C_BEQ || c == C_BNE;
            pw = (c == C_BEQ && z) || (c == C_BNE && !z);
            op = c == C_R ? 4'd15 : br ? 4'd1 : c == C_ORI ? 4'd3 : c == C_LUI ? 4'd5 : 4'd0;
            chk("ex", 3'd2, v(pw, br ? 2'd1 : 2'd0, 0, 0, 0, 0,
                {c == C_ADDI || c == C_ORI || c == C_LUI || lw || sw, 1'b0, 1'b0,
                 c == C_ADDI || lw || sw || br, 1'b0, c == C_R}, 0, 0), op);
            if (br) begin
                exp_ir++;
                chk_ir("br_ir");
                return;
            end
            if (lw || sw) begin
                for (int k = 0; k < mem_lat; k++) begin
                    mem_ready = 1'b0;
                    if (k == TMO - 1) begin
                        chk("mem_tmo", 3'd3, v(0, 0, 0, 0, 0, 0, 6'd0, 1, 0), 4'd0);
                        chk_ir("mem_tmo_ir");
                        return;
                    end
                    chk("mem_wait", 3'd3, v(0, 0, 0, lw, sw, 0, 6'd0, 0, 0), 4'd0);
                end
                mem_ready = 1'b1;
                chk("mem_done", 3'd3, v(0, 0, 0, lw, sw, 0, 6'd0, 0, 0), 4'd0);
                mem_ready = 1'($urandom);
                if (sw) begin
                    exp_ir++;
                    chk_ir("sw_ir");
                    return;
                end
            end
        end
        chk("wb", 3'd4, v(0, 0, 0, 0, 0, 1, {1'b0, c == C_R, lw, 1'b0, c == C_JAL, 1'b0}, 0, 0), 4'd0);
        exp_ir++;
        chk_ir("wb_ir");
    endtask
    initial begin
        logic [5:0] ops [10];
        logic [31:0] ins;
        int il, ml;
        ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h00};
        rst = 1'b1;
        zero = 1'b0;
        mem_ready = 1'b0;
        instruction = 32'd0;
        exp_ir = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_ir("reset");
        rst = 1'b0;
        run(32'h00221820, 0, 0, 0);
        run(32'h8C220004, 0, 0, 3);
        run(32'h10220003, 1, 0, 0);
        run(32'h14220003, 1, 0, 0);
        run(32'h0C000010, 0, 0, 0);
        run(32'h08000010, 0, 0, 0);
        run(32'h00221820, 0, 15, 0);
        run(32'h00221820, 0, 14, 0);
        run(32'h8C220004, 0, 0, 15);
        run(32'hAC220004, 0, 1, 14);
        run(32'hFC000000, 0, 0, 0);
        run(32'h00000000, 0, 0, 0);
        run(32'h20220005, 0, 0, 0);
        run(32'h34220005, 0, 0, 0);
        run(32'h3C020005, 0, 0, 0);
        run(32'h10220003, 0, 0, 0);
        run(32'h14220003, 0, 0, 0);
        instruction = 32'hAC220004;
        mem_ready = 1'b1;
        chk("rs_if", 3'd0, v(1, 0, 1, 1, 0, 0, 6'd0, 0, 0), 4'd0);
        mem_ready = 1'b0;
        chk("rs_id", 3'd1, v(0, 0, 0, 0, 0, 0, 6'd0, 0, 0), 4'd0);
        chk("rs_ex", 3'd2, v(0, 0, 0, 0, 0, 0, 6'b100100, 0, 0), 4'd0);
        rst = 1'b1;
        chk("rs_mem", 3'd3, v(0, 0, 0, 0, 1, 0, 6'd0, 0, 0), 4'd0);
        rst = 1'b0;
        exp_ir = '0;
        chk_ir("rs_abort");
        for (int n = 0; n < 90; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    ins = $urandom;
                2:       ins = {6'd0, 20'($urandom), 6'($urandom_range(1, 63))};
                3:       ins = 32'd0;
                default: ins = {ops[$urandom_range(0, 9)], 26'($urandom)};
            endcase
            il = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            ml = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            run(ins, 1'($urandom), il, ml);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
